// File: rtl/line_mem_ctrl.sv
// rtl/line_mem_ctrl.sv - line-burst backing memory controller for the data cache
//
// Purpose: services whole-line fill and writeback requests from the cache miss
// handler. After a fixed access latency, one word moves per cycle in a burst
// over a word-addressed storage array.
//
// Ports:
//   CLK       in   1  clock, rising edge
//   RST       in   1  asynchronous active-low reset
//   REQ       in   1  request strobe, sampled only in IDLE
//   REQ_WE    in   1  1 = line writeback, 0 = line fill
//   REQ_ADDR  in  32  word address, line-aligned internally
//   WDATA     in  32  writeback word, written on each WREADY cycle
//   WREADY    out  1  write beat accepted this cycle
//   RDATA     out 32  fill word, 0 when RVALID=0
//   RVALID    out  1  fill beat valid this cycle
//   RLAST     out  1  final fill beat
//   BUSY      out  1  transaction in progress
//   DONE      out  1  one-cycle pulse at end of every transaction
module line_mem_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 4,
  parameter int DEPTH      = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic        REQ_WE,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] WDATA,
  output logic        WREADY,
  output logic [31:0] RDATA,
  output logic        RVALID,
  output logic        RLAST,
  output logic        BUSY,
  output logic        DONE
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(LINE_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RBURST,
    S_WBURST,
    S_FIN
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   base;
  logic            we_q;
  logic [7:0]      cnt;
  logic [BW-1:0]   beat;
  logic [AW-1:0]   idx;
  logic            last_beat;
  logic [31:0]     mem [DEPTH];

  // Upper address bits alias onto the array and are deliberately dropped.
  logic            unused_addr;
  assign unused_addr = ^REQ_ADDR[31:AW];

  // base is line-aligned, so this sum never carries out of the line.
  assign idx       = base + AW'(beat);
  assign last_beat = (beat == BW'(LINE_WORDS - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (REQ) state_nxt = S_WAIT;
      S_WAIT:   if (cnt == 8'd0) state_nxt = we_q ? S_WBURST : S_RBURST;
      S_RBURST: if (last_beat) state_nxt = S_FIN;
      S_WBURST: if (last_beat) state_nxt = S_FIN;
      S_FIN:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      base <= '0;
      we_q <= 1'b0;
      cnt  <= '0;
      beat <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (REQ) begin
            base <= REQ_ADDR[AW-1:0] & ~AW'(LINE_WORDS - 1);
            we_q <= REQ_WE;
            cnt  <= 8'(LATENCY);
          end
        end
        S_WAIT: begin
          if (cnt == 8'd0) beat <= '0;
          else             cnt  <= cnt - 8'd1;
        end
        S_RBURST, S_WBURST: beat <= beat + BW'(1);
        default: ;
      endcase
    end
  end

  // Storage is never reset so contents survive an aborted transaction.
  always_ff @(posedge CLK) begin
    if (state == S_WBURST) mem[idx] <= WDATA;
  end

  // Outputs decode the state register only, so reset clears them at once.
  assign WREADY = (state == S_WBURST);
  assign RVALID = (state == S_RBURST);
  assign RDATA  = RVALID ? mem[idx] : 32'd0;
  assign RLAST  = RVALID & last_beat;
  assign BUSY   = (state != S_IDLE);
  assign DONE   = (state == S_FIN);

endmodule

// File: tb/tb_line_mem_ctrl.sv
// tb/tb_line_mem_ctrl.sv - self-checking bench for line_mem_ctrl
module tb_line_mem_ctrl;

  localparam int LAT = 4;
  localparam int LW  = 4;

  logic        clk;
  logic        rst;
  logic        req;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] wdata;
  logic        wready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rlast;
  logic        busy;
  logic        done;

  line_mem_ctrl #(.LINE_WORDS(LW), .LATENCY(LAT), .DEPTH(1024)) dut (
    .CLK(clk), .RST(rst), .REQ(req), .REQ_WE(req_we), .REQ_ADDR(req_addr),
    .WDATA(wdata), .WREADY(wready), .RDATA(rdata), .RVALID(rvalid),
    .RLAST(rlast), .BUSY(busy), .DONE(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // flags = {wready, rvalid, rlast, busy, done}
  typedef struct {
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  flags;
    logic [31:0] rdata;
  } vec_t;

  localparam logic [4:0] F_IDLE  = 5'b00000;
  localparam logic [4:0] F_WAIT  = 5'b00010;
  localparam logic [4:0] F_WB    = 5'b10010;
  localparam logic [4:0] F_RB    = 5'b01010;
  localparam logic [4:0] F_RLAST = 5'b01110;
  localparam logic [4:0] F_FIN   = 5'b00011;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic q, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [4:0] fl, input logic [31:0] rd);
    vec_t v;
    v.rst = r; v.req = q; v.we = w; v.addr = a; v.wdata = wd; v.flags = fl; v.rdata = rd;
    vecs.push_back(v);
  endtask

  // One whole transaction: accept cycle in IDLE, LAT+1 WAIT cycles, LW beats, FIN.
  task automatic add_txn(input logic w, input logic [31:0] a);
    add(1'b1, 1'b1, w, a, 32'd0, F_IDLE, 32'd0);
    for (int i = 0; i <= LAT; i++) add(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, F_WAIT, 32'd0);
    for (int k = 0; k < LW; k++) begin
      if (w) add(1'b1, 1'b0, 1'b0, 32'd0, 32'(-(k + 1)), F_WB, 32'd0);
      else   add(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, (k == LW - 1) ? F_RLAST : F_RB, 32'(-(k + 1)));
    end
    add(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, F_FIN, 32'd0);
  endtask

  task automatic wait_rvalid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (rvalid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_fill(input logic [31:0] a, input string tag);
    bit ok;
    @(negedge clk);
    req = 1'b1; req_we = 1'b0; req_addr = a;
    @(negedge clk);
    req = 1'b0;
    wait_rvalid(ok);
    if (!ok) chk({tag, "_timeout"}, 40'd0, 40'd1);
    for (int k = 0; k < LW; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      chk({tag, "_rvalid"}, {39'd0, rvalid}, 40'd1);
      chk({tag, "_rdata"}, {8'd0, rdata}, {8'd0, 32'(-(k + 1))});
      chk({tag, "_rlast"}, {39'd0, rlast}, {39'd0, (k == LW - 1)});
    end
    @(negedge clk);
    #1;
    chk({tag, "_done"}, {39'd0, done}, 40'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  dones;
    bit  ok;
    logic [4:0] fl;

    rst = 1'b1; req = 1'b0; req_we = 1'b0; req_addr = 32'd0; wdata = 32'd0;
    #1 rst = 1'b0;

    // Reset held with REQ asserted: nothing accepted, all outputs low.
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b0, 32'd20, 32'd0, F_IDLE, 32'd0);
    add_txn(1'b1, 32'd20);
    add_txn(1'b0, 32'd22);
    add(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, F_IDLE, 32'd0);
    add_txn(1'b0, 32'd1044);
    add(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, F_IDLE, 32'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; req = vecs[i].req; req_we = vecs[i].we;
      req_addr = vecs[i].addr; wdata = vecs[i].wdata;
      #1;
      fl = {wready, rvalid, rlast, busy, done};
      chk($sformatf("vec%0d_flags", i), {35'd0, fl}, {35'd0, vecs[i].flags});
      chk($sformatf("vec%0d_rdata", i), {8'd0, rdata}, {8'd0, vecs[i].rdata});
    end

    // Held request: two back-to-back fills, 10 BUSY cycles each, 1-cycle IDLE gap.
    dones = 0;
    for (int c = 0; c <= 22; c++) begin
      @(negedge clk);
      if (c == 0) begin
        req = 1'b1; req_we = 1'b0; req_addr = 32'd0;
      end
      if (c == 22) req = 1'b0;
      #1;
      chk($sformatf("held_busy_c%0d", c), {39'd0, busy}, {39'd0, !(c == 0 || c == 11 || c == 22)});
      if (done) dones++;
    end
    chk("held_done_count", 40'(dones), 40'd2);
    @(negedge clk);
    #1;
    chk("held_no_third", {39'd0, busy}, 40'd0);

    // Reset during the second fill beat.
    @(negedge clk);
    req = 1'b1; req_we = 1'b0; req_addr = 32'd20;
    @(negedge clk);
    req = 1'b0;
    wait_rvalid(ok);
    if (!ok) chk("abort_timeout", 40'd0, 40'd1);
    chk("abort_beat0", {8'd0, rdata}, {8'd0, 32'hFFFF_FFFF});
    @(negedge clk);
    #1;
    chk("abort_beat1", {7'd0, rvalid, rdata}, {7'd0, 1'b1, 32'hFFFF_FFFE});
    rst = 1'b0;
    #1;
    fl = {wready, rvalid, rlast, busy, done};
    chk("abort_flags", {35'd0, fl}, 40'd0);
    chk("abort_rdata", {8'd0, rdata}, 40'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    fl = {wready, rvalid, rlast, busy, done};
    chk("abort_after_release", {35'd0, fl}, 40'd0);
    @(negedge clk);
    #1;
    chk("abort_no_done", {39'd0, done}, 40'd0);

    do_fill(32'd20, "refill");
    do_fill(32'd1047, "wrapfill");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
